// File: rtl/rr_sched8.sv
// Round-robin scheduler for an 8-way shared resource with a per-session hold limit.
// Drives a 3-bit decoder select plus the matching one-hot grant vector.
module rr_sched8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       timeout_q, timeout_d;

  logic       any_req;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       rel_done, rel_withdraw, rel_limit;

  // Scan from ptr+7 down to ptr so the entry closest to ptr is written last and wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) winner = cand;
    end
  end

  assign any_req      = |req;
  assign rel_done     = done;
  assign rel_withdraw = ~req[gnt_idx_q];
  assign rel_limit    = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = winner;
          hold_cnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (rel_done || rel_withdraw || rel_limit) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          // A voluntary release on the limit cycle is not a timeout.
          timeout_d   = rel_limit && !rel_done && !rel_withdraw;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 8'd0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= 3'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      timeout_q   <= timeout_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign gnt[gi] = gnt_valid_q && (gnt_idx_q == 3'(gi));
    end
  endgenerate

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule
